// File: rtl/sublime_wavegen_if.sv
// Sample-strobe bus between the NCO side (master) and sublime_wavegen (slave).
// Valid/ready: in_valid/out_valid are single-cycle strobes with no ready; every strobe is a transfer.
interface sublime_wavegen_if #(
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic [31:0]      phase;
  logic [1:0]       shape;
  logic [31:0]      pulse_width;
  logic             out_valid;
  logic [OUT_W-1:0] sample;
  logic             wrap;

  modport master (
    output in_valid, phase, shape, pulse_width,
    input  out_valid, sample, wrap
  );

  modport slave (
    input  in_valid, phase, shape, pulse_width,
    output out_valid, sample, wrap
  );
endinterface

// File: rtl/sublime_wavegen.sv
// Phase-to-waveform shaper (saw/pulse/triangle/sine), fixed 3-stage pipeline with hard-sync wrap pulse.
// Optional sine ROM enabled by defining SUBLIME_WAVEGEN_SINE_EN; otherwise shape 3 yields 0x0000.
module sublime_wavegen #(
  parameter int OUT_W  = 16,
  parameter int LUT_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  sublime_wavegen_if.slave   bus
);

  if (OUT_W != 16 || LUT_AW < 1 || LUT_AW > 30) begin : g_param_check
    $error("sublime_wavegen: unsupported OUT_W or LUT_AW");
  end

  // ---------------- stage 1: capture inputs, detect wrap ----------------
  logic        s1_valid;
  logic        s1_wrap;
  logic        prev_msb;
  logic [31:0] s1_phase;
  logic [31:0] s1_pw;
  logic [1:0]  s1_shape;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_wrap  <= 1'b0;
      prev_msb <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_wrap  <= bus.in_valid & prev_msb & ~bus.phase[31];
      if (bus.in_valid) prev_msb <= bus.phase[31];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      s1_phase <= bus.phase;
      s1_pw    <= bus.pulse_width;
      s1_shape <= bus.shape;
    end
  end

  // ---------------- stage 2: shape computation ----------------
  logic [15:0] tri_t;
  logic [15:0] shape_val;

  always_comb begin
    tri_t     = s1_phase[31] ? ~s1_phase[30:15] : s1_phase[30:15];
    shape_val = 16'h0000;
    case (s1_shape)
      2'd0:    shape_val = {~s1_phase[31], s1_phase[30:16]};
      2'd1:    shape_val = (s1_phase < s1_pw) ? 16'h7FFF : 16'h8001;
      2'd2:    shape_val = tri_t ^ 16'h8000;
      default: shape_val = 16'h0000;
    endcase
  end

  logic        s2_valid;
  logic        s2_wrap;
  logic [15:0] s2_sample;
  logic [15:0] s2_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_wrap  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_wrap  <= s1_valid & s1_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid) s2_sample <= shape_val;
  end

`ifdef SUBLIME_WAVEGEN_SINE_EN
  localparam int  ROM_N   = 1 << LUT_AW;
  localparam real HALF_PI = 1.5707963267948966;

  logic [14:0]       sine_rom [ROM_N];
  logic [LUT_AW-1:0] rom_idx;
  logic [14:0]       rom_q;
  logic              s2_is_sine;
  logic              s2_neg;

  // Quarter-wave table sampled at bin centres; peak capped at 32766 so +/- peaks stay symmetric.
  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    localparam real ANG     = HALF_PI * (real'(k) + 0.5) / real'(ROM_N);
    localparam int  MAG_RAW = $rtoi(32767.0 * $sin(ANG) + 0.5);
    localparam int  MAG     = (MAG_RAW > 32766) ? 32766 : MAG_RAW;
    assign sine_rom[k] = 15'(MAG);
  end

  assign rom_idx = s1_phase[30] ? ~s1_phase[29 -: LUT_AW] : s1_phase[29 -: LUT_AW];

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      rom_q      <= sine_rom[rom_idx];
      s2_is_sine <= (s1_shape == 2'd3);
      s2_neg     <= s1_phase[31];
    end
  end

  always_comb begin
    s2_out = s2_sample;
    if (s2_is_sine) s2_out = s2_neg ? (16'd0 - {1'b0, rom_q}) : {1'b0, rom_q};
  end
`else
  assign s2_out = s2_sample;
`endif

  // ---------------- stage 3: output registers ----------------
  logic             out_valid_q;
  logic             wrap_q;
  logic [OUT_W-1:0] sample_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      sample_q    <= '0;
    end else begin
      out_valid_q <= s2_valid;
      wrap_q      <= s2_valid & s2_wrap;
      if (s2_valid) sample_q <= OUT_W'(s2_out);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.wrap      = wrap_q;
  assign bus.sample    = sample_q;

endmodule

// File: tb/tb_sublime_wavegen.sv
// Bench for sublime_wavegen: directed vectors, arithmetic reference model, per-cycle compare.
module tb_sublime_wavegen;

  logic clk;
  logic rst;
  int unsigned cyc;
  int n_checks;
  int n_errors;
  bit chk_en;
  logic [15:0] hold_s;
  logic m_prev_msb;

  typedef struct {
    int unsigned due;
    logic [15:0] s;
    logic        w;
    int          lit_s;
    int          lit_w;
  } item_t;

  item_t exp_q[$];

  sublime_wavegen_if #(.OUT_W(16)) bus ();

  sublime_wavegen #(.OUT_W(16), .LUT_AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic longint sine_model(input logic [31:0] p);
`ifdef SUBLIME_WAVEGEN_SINE_EN
    real a;
    int  n;
    int  mag;
    n = int'(p >> 22);
    a = $sin(2.0 * 3.14159265358979 * (real'(n) + 0.5) / 1024.0);
    if (a < 0.0) a = -a;
    mag = $rtoi(32767.0 * a + 0.5);
    if (mag > 32766) mag = 32766;
    return (n >= 512) ? -longint'(mag) : longint'(mag);
`else
    return (p == 32'd0) ? 0 : 0;
`endif
  endfunction

  function automatic logic [15:0] model_sample(input logic [31:0] p, input logic [1:0] sh,
                                               input logic [31:0] pw);
    longint v;
    longint up;
    up = longint'(p);
    v  = 0;
    case (sh)
      2'd0: v = up / 65536 - 32768;
      2'd1: v = (p < pw) ? 32767 : -32767;
      2'd2: v = (up < 64'd2147483648) ? (up / 32768 - 32768)
                                       : ((64'd4294967295 - up) / 32768 - 32768);
      default: v = sine_model(p);
    endcase
    return v[15:0];
  endfunction

  // ---------------- checker helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        item_t it;
        it = exp_q.pop_front();
        chk("out_valid_hi", 32'(bus.out_valid), 32'd1);
        chk("sample", 32'(bus.sample), 32'(it.s));
        chk("wrap", 32'(bus.wrap), 32'(it.w));
        if (it.lit_s >= 0) chk("lit_sample", 32'(bus.sample), 32'(it.lit_s[15:0]));
        if (it.lit_w >= 0) chk("lit_wrap", 32'(bus.wrap), 32'(it.lit_w[0]));
        hold_s = it.s;
      end else begin
        chk("out_valid_lo", 32'(bus.out_valid), 32'd0);
        chk("sample_hold", 32'(bus.sample), 32'(hold_s));
        chk("wrap_lo", 32'(bus.wrap), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] p, input logic [1:0] sh, input logic [31:0] pw,
                      input int lit_s, input int lit_w);
    item_t it;
    bus.in_valid    = 1'b1;
    bus.phase       = p;
    bus.shape       = sh;
    bus.pulse_width = pw;
    it.due   = cyc + 3;
    it.s     = model_sample(p, sh, pw);
    it.w     = m_prev_msb && !p[31];
    it.lit_s = lit_s;
    it.lit_w = lit_w;
    m_prev_msb = p[31];
    exp_q.push_back(it);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    hold_s     = 16'h0000;
    m_prev_msb = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    n_checks    = 0;
    n_errors    = 0;
    chk_en      = 1'b0;
    hold_s      = 16'h0000;
    m_prev_msb  = 1'b0;
    rst         = 1'b1;
    bus.in_valid    = 1'b0;
    bus.phase       = 32'd0;
    bus.shape       = 2'd0;
    bus.pulse_width = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_sample", 32'(bus.sample), 32'd0);
    chk("reset_wrap", 32'(bus.wrap), 32'd0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // saw
    send(32'h0000_0000, 2'd0, 32'd0, 16'h8000, -1);
    send(32'h8000_0000, 2'd0, 32'd0, 16'h0000, -1);
    send(32'hFFFF_FFFF, 2'd0, 32'd0, 16'h7FFF, -1);
    idle(4);

    // pulse
    send(32'h4000_0000, 2'd1, 32'h8000_0000, 16'h7FFF, -1);
    send(32'hC000_0000, 2'd1, 32'h8000_0000, 16'h8001, -1);
    send(32'h0000_0000, 2'd1, 32'h0000_0000, 16'h8001, -1);
    send(32'h1234_5678, 2'd1, 32'h0000_0000, 16'h8001, -1);
    send(32'hFFFF_FFFF, 2'd1, 32'h0000_0000, 16'h8001, -1);
    idle(3);

    // triangle
    send(32'h0000_0000, 2'd2, 32'd0, 16'h8000, -1);
    send(32'h4000_0000, 2'd2, 32'd0, 16'h0000, -1);
    send(32'h8000_0000, 2'd2, 32'd0, 16'h7FFF, -1);
    idle(3);

    // sine (or silence when the ROM is not built)
`ifdef SUBLIME_WAVEGEN_SINE_EN
    send(32'h4000_0000, 2'd3, 32'd0, 16'h7FFE, -1);
    send(32'hC000_0000, 2'd3, 32'd0, 16'h8002, -1);
`else
    send(32'h4000_0000, 2'd3, 32'd0, 16'h0000, -1);
    send(32'hC000_0000, 2'd3, 32'd0, 16'h0000, -1);
`endif
    idle(4);

    // wrap: first sample after reset never wraps, then a back-to-back wrap sequence
    pulse_reset();
    idle(2);
    send(32'h1000_0000, 2'd0, 32'd0, -1, 0);
    idle(2);
    send(32'hF000_0000, 2'd0, 32'd0, -1, 0);
    send(32'h1000_0000, 2'd0, 32'd0, -1, 1);
    send(32'h3000_0000, 2'd0, 32'd0, -1, 0);
    idle(4);

    // mixed shapes and gaps across the phase range
    for (int i = 0; i < 24; i++) begin
      send(32'(i) * 32'h0B50_0000 + 32'h0123_4567, 2'(i % 4), 32'h6000_0000, -1, -1);
      if (i % 5 == 4) idle(2);
    end
    idle(4);

    // reset in the cycle after the last of three back-to-back samples
    send(32'h2000_0000, 2'd0, 32'd0, -1, -1);
    send(32'hA000_0000, 2'd2, 32'd0, -1, -1);
    send(32'h6000_0000, 2'd1, 32'h7000_0000, -1, -1);
    pulse_reset();
    idle(8);
    send(32'h9000_0000, 2'd0, 32'd0, 16'h1000, 0);

    t = 0;
    while (exp_q.size() > 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    idle(3);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sublime_wavegen.md
# sublime_wavegen

Waveform shaper sitting directly downstream of the synth's numerically controlled oscillator (NCO). It consumes the NCO's 32-bit phase word on a per-sample strobe and produces a signed sample through a fixed 3-stage pipeline, ready for the filter/VCA chain. The selectable shapes are saw, pulse, triangle and optional sine. It also emits a phase-wrap pulse that can drive the sync input of a slave NCO (hard sync).

## Interface
Parameters:
- OUT_W, 16, sample width; only 16 is supported.
- LUT_AW, 8, sine quarter-wave table address width (256 entries).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  sample strobe; phase, shape and pulse_width are sampled when high
- phase  in  32  NCO phase word (0 = start of cycle, 2^32 = full cycle)
- shape  in  2  waveform: 0 = saw, 1 = pulse, 2 = triangle, 3 = sine
- pulse_width  in  32  pulse threshold, in phase units
- out_valid  out  1  one-cycle strobe marking a new sample
- sample  out  OUT_W  signed two's-complement sample; held between strobes
- wrap  out  1  high together with out_valid when this sample's phase wrapped

## Operation
- No backpressure. in_valid may be high every cycle, and every accepted input produces exactly one output.
- Stage 1 registers phase, shape, pulse_width and the valid bit. It also computes wrap: the previously accepted phase[31] is 1 and the current phase[31] is 0. The previous-MSB register updates only on in_valid.
- Stage 2 computes the shape:
  - Saw: {~phase[31], phase[30:16]}.
  - Pulse: 0x7FFF if phase < pulse_width (unsigned), else 0x8001. Consequently pulse_width = 0 gives a constant 0x8001.
  - Triangle: t = phase[31] ? ~phase[30:15] : phase[30:15], then sample = t ^ 0x8000.
  - Sine:
    - quadrant q = phase[31:30], index i = phase[29:22];
    - if q is odd, use ~i;
    - look up ROM, where ROM[k] = round(32767*sin(pi/2*(k+0.5)/256));
    - negate the result for q = 2 or 3.
- Stage 3 registers sample, wrap and out_valid.
- sample, wrap and out_valid reset to 0. All pipeline valid bits and the previous-MSB register also clear on reset.
- Reset asserted mid-operation drops every in-flight sample. No out_valid appears until 3 cycles after the first post-reset in_valid.
- A shape change takes effect on the next accepted sample; there is no glitch suppression.
- wrap is 0 whenever out_valid is 0.

## Timing
- Latency: in_valid in cycle N gives out_valid in cycle N+3. This holds for every shape, with or without the sine option.
- Throughput: one sample per cycle.
- The sine ROM is a synchronous read in stage 2, so the ROM output lands in stage 3. Other shapes are delay-matched to it.
- sample and wrap keep their values until the next out_valid.

## Configuration
- SUBLIME_WAVEGEN_SINE_EN defined: shape 3 produces sine from the quarter-wave ROM.
- SUBLIME_WAVEGEN_SINE_EN undefined: no ROM is built, and shape 3 produces 0x0000 with normal out_valid and wrap timing. Shapes 0–2 are unaffected.

## Test plan
- Saw: phases 0x00000000, 0x80000000, 0xFFFFFFFF → samples 0x8000, 0x0000, 0x7FFF, each out_valid exactly 3 cycles after its in_valid.
- Pulse with pulse_width = 0x80000000:
  - phase 0x40000000 → 0x7FFF; phase 0xC0000000 → 0x8001;
  - pulse_width = 0 with any phase → 0x8001.
- Triangle: phases 0x00000000, 0x40000000, 0x80000000 → 0x8000, 0x0000, 0x7FFF.
- Sine (macro defined): phase 0x40000000 → 0x7FFE (32766); phase 0xC0000000 → 0x8002. With the macro undefined, the same inputs → 0x0000.
- Wrap: back-to-back in_valid with phases 0xF0000000, 0x10000000, 0x30000000 → wrap = 0, 1, 0 on consecutive out_valid cycles. The first sample after reset with phase 0x10000000 → wrap = 0.
- Reset: issue 3 back-to-back samples, then pulse rst in the cycle after the last in_valid → no out_valid afterwards; sample = 0 and wrap = 0 until a new input arrives.
